seq_detect_param: RTL



---
 rtl/seq_detect_param.sv | 89 ++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial pattern detector with run-time overlap select.
// Define SEQ_DETECT_MATCH_COUNT_EN to build the saturating match counter.
module seq_detect_param #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             in_valid,
  input  logic             a,
  input  logic             overlap,
  input  logic             clr,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int               FILL_W   = $clog2(WIDTH);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIDTH - 1);

  logic [WIDTH-1:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic              y_r;
  logic [WIDTH-1:0]  cand_s;
  logic              hit_s;
  logic [FILL_W-1:0] fill_nxt_s;

  assign cand_s = {hist_r[WIDTH-2:0], a};
  assign hit_s  = in_valid && (fill_r == FILL_MAX) && (cand_s == PATTERN);

  // Fill restarts after a non-overlapping match, otherwise saturates at WIDTH-1.
  always_comb begin
    fill_nxt_s = fill_r;
    if (hit_s && !overlap) begin
      fill_nxt_s = '0;
    end else if (fill_r == FILL_MAX) begin
      fill_nxt_s = fill_r;
    end else begin
      fill_nxt_s = fill_r + FILL_W'(1);
    end
  end

  // History, fill level and match pulse registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      hist_r <= '0;
      fill_r <= '0;
      y_r    <= 1'b0;
    end else if (clr) begin
      hist_r <= '0;
      fill_r <= '0;
      y_r    <= 1'b0;
    end else if (in_valid) begin
      hist_r <= cand_s;
      fill_r <= fill_nxt_s;
      y_r    <= hit_s;
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
      y_r    <= 1'b0;
    end
  end

  assign y = y_r;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_r;

  // Saturating match counter; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (hit_s && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign match_cnt = cnt_r;
`else
  assign match_cnt = '0;
`endif

endmodule
